// File: rtl/disp_pkg.sv
// Shared types and defaults for the digit scan/select block.
// State encoding plus the parameter defaults used by the top.
package disp_pkg;

  typedef enum logic {
    SHOW_COUNT = 1'b0,
    SHOW_ERR   = 1'b1
  } disp_state_t;

  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W    = 4;
  localparam int DEF_SCAN_DIV   = 1000;
  localparam int DEF_BLINK_DIV  = 25000000;

endpackage

// File: rtl/disp_scan_select_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks.
// clr holds the count at zero so the first tick comes DIV clocks later.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_select.sv
// Multiplexed display driver: scans frame-snapshotted count digits,
// or a latched error code that blinks while the error is pending.
module disp_scan_select
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W    = DEF_DIGIT_W,
  parameter int SCAN_DIV   = DEF_SCAN_DIV,
  parameter int BLINK_DIV  = DEF_BLINK_DIV
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] count_bus,
  input  logic                          err_req,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] err_code,
  input  logic                          err_clr,
  output logic [NUM_DIGITS-1:0]         dig_sel,
  output logic [DIGIT_W-1:0]            dig_val,
  output logic                          is_err
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = NUM_DIGITS * DIGIT_W;

  disp_state_t state, state_nx;

  logic [IW-1:0]         idx;
  logic [BW-1:0]         count_snap;
  logic [BW-1:0]         err_hold;
  logic                  phase_on;
  logic                  scan_tick;
  logic                  blink_tick;
  logic                  wrap;
  logic [DIGIT_W-1:0]    cur_digit;
  logic [NUM_DIGITS-1:0] one_hot;

  tick_gen #(.DIV(SCAN_DIV)) u_scan (
    .clk   (clk),
    .reset (reset),
    .clr   (1'b0),
    .tick  (scan_tick)
  );

  tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk   (clk),
    .reset (reset),
    .clr   (state == SHOW_COUNT),
    .tick  (blink_tick)
  );

  assign is_err = (state == SHOW_ERR);
  assign wrap   = scan_tick && (idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      SHOW_COUNT: if (err_req) state_nx = SHOW_ERR;
      SHOW_ERR:   if (err_clr && !err_req) state_nx = SHOW_COUNT;
      default:    state_nx = SHOW_COUNT;
    endcase
  end

  always_comb begin
    one_hot = '0;
    one_hot[idx] = 1'b1;
    if (is_err) begin
      cur_digit = err_hold[int'(idx)*DIGIT_W +: DIGIT_W];
    end else begin
      cur_digit = count_snap[int'(idx)*DIGIT_W +: DIGIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= SHOW_COUNT;
      idx        <= '0;
      count_snap <= '0;
      err_hold   <= '0;
      phase_on   <= 1'b1;
    end else begin
      state <= state_nx;
      if (err_req) err_hold <= err_code;
      if (wrap) begin
        idx        <= '0;
        count_snap <= count_bus;
      end else if (scan_tick) begin
        idx <= idx + 1'b1;
      end
      if (state == SHOW_COUNT) begin
        phase_on <= 1'b1;
      end else if (blink_tick) begin
        phase_on <= ~phase_on;
      end
    end
  end

  // Outputs lag idx/source by one clock; blanking only applies in error.
  always_ff @(posedge clk) begin
    if (reset) begin
      dig_sel <= NUM_DIGITS'(1);
      dig_val <= '0;
    end else begin
      dig_sel <= (is_err && !phase_on) ? '0 : one_hot;
      dig_val <= cur_digit;
    end
  end

endmodule

// File: tb/tb_disp_scan_select.sv
// Directed bench: timed vector table plus a reset-in-error sequence.
// Cycle numbers count rising edges after the last reset edge.
module tb_disp_scan_select;

  logic        clk;
  logic        reset;
  logic [15:0] count_bus;
  logic        err_req;
  logic [15:0] err_code;
  logic        err_clr;
  logic [3:0]  dig_sel;
  logic [3:0]  dig_val;
  logic        is_err;

  int total;
  int bad;
  int cur;

  typedef struct {
    int          at;
    logic [15:0] cnt;
    logic        req;
    logic        clr;
    logic [15:0] code;
    logic [3:0]  sel;
    logic [3:0]  val;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  disp_scan_select #(
    .NUM_DIGITS (4),
    .DIGIT_W    (4),
    .SCAN_DIV   (4),
    .BLINK_DIV  (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .count_bus (count_bus),
    .err_req   (err_req),
    .err_code  (err_code),
    .err_clr   (err_clr),
    .dig_sel   (dig_sel),
    .dig_val   (dig_val),
    .is_err    (is_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cur++;
  endtask

  task automatic check(input string nm, input logic [3:0] sel,
                       input logic [3:0] val, input logic err);
    total++;
    if (dig_sel !== sel || dig_val !== val || is_err !== err) begin
      bad++;
      $display("FAIL %s cyc=%0d got sel=%b val=%h err=%b want sel=%b val=%h err=%b",
               nm, cur, dig_sel, dig_val, is_err, sel, val, err);
    end
  endtask

  function automatic vec_t mk(int at, logic [15:0] cnt, logic req,
                              logic clr, logic [15:0] code,
                              logic [3:0] sel, logic [3:0] val,
                              logic err);
    vec_t v;
    v.at = at; v.cnt = cnt; v.req = req; v.clr = clr;
    v.code = code; v.sel = sel; v.val = val; v.err = err;
    return v;
  endfunction

  initial begin
    total = 0;
    bad = 0;
    cur = 0;

    vecs.push_back(mk(  0, 16'h4321, 0, 0, 16'h0, 4'b0001, 4'h0, 0));
    vecs.push_back(mk(  8, 16'h4321, 0, 0, 16'h0, 4'b0010, 4'h0, 0));
    vecs.push_back(mk( 17, 16'h4321, 0, 0, 16'h0, 4'b0001, 4'h1, 0));
    vecs.push_back(mk( 20, 16'h4321, 0, 0, 16'h0, 4'b0001, 4'h1, 0));
    vecs.push_back(mk( 21, 16'h4321, 0, 0, 16'h0, 4'b0010, 4'h2, 0));
    vecs.push_back(mk( 24, 16'h4321, 0, 0, 16'h0, 4'b0010, 4'h2, 0));
    vecs.push_back(mk( 25, 16'h8765, 0, 0, 16'h0, 4'b0100, 4'h3, 0));
    vecs.push_back(mk( 29, 16'h8765, 0, 0, 16'h0, 4'b1000, 4'h4, 0));
    vecs.push_back(mk( 32, 16'h8765, 0, 0, 16'h0, 4'b1000, 4'h4, 0));
    vecs.push_back(mk( 33, 16'h8765, 0, 0, 16'h0, 4'b0001, 4'h5, 0));
    vecs.push_back(mk( 37, 16'h8765, 0, 1, 16'h0, 4'b0010, 4'h6, 0));
    vecs.push_back(mk( 41, 16'h8765, 0, 1, 16'h0, 4'b0100, 4'h7, 0));
    vecs.push_back(mk( 45, 16'h8765, 0, 0, 16'h0, 4'b1000, 4'h8, 0));
    vecs.push_back(mk( 49, 16'h8765, 0, 0, 16'h0, 4'b0001, 4'h5, 0));
    vecs.push_back(mk( 50, 16'h8765, 1, 0, 16'hEC01, 4'b0001, 4'h5, 1));
    vecs.push_back(mk( 51, 16'h8765, 0, 0, 16'h0, 4'b0001, 4'h1, 1));
    vecs.push_back(mk( 53, 16'h8765, 0, 0, 16'h0, 4'b0010, 4'h0, 1));
    vecs.push_back(mk( 57, 16'h8765, 0, 0, 16'h0, 4'b0100, 4'hC, 1));
    vecs.push_back(mk( 61, 16'h8765, 0, 0, 16'h0, 4'b1000, 4'hE, 1));
    vecs.push_back(mk( 66, 16'h8765, 0, 0, 16'h0, 4'b0001, 4'h1, 1));
    vecs.push_back(mk( 67, 16'h8765, 0, 0, 16'h0, 4'b0000, 4'h1, 1));
    vecs.push_back(mk( 70, 16'h8765, 0, 0, 16'h0, 4'b0000, 4'h0, 1));
    vecs.push_back(mk( 82, 16'h8765, 0, 0, 16'h0, 4'b0000, 4'h1, 1));
    vecs.push_back(mk( 83, 16'h8765, 0, 0, 16'h0, 4'b0001, 4'h1, 1));
    vecs.push_back(mk( 85, 16'h8765, 0, 0, 16'h0, 4'b0010, 4'h0, 1));
    vecs.push_back(mk( 86, 16'h8765, 1, 1, 16'hEC02, 4'b0010, 4'h0, 1));
    vecs.push_back(mk( 97, 16'h8765, 0, 0, 16'h0, 4'b0001, 4'h2, 1));
    vecs.push_back(mk( 99, 16'h8765, 0, 0, 16'h0, 4'b0000, 4'h2, 1));
    vecs.push_back(mk(100, 16'h8765, 0, 1, 16'h0, 4'b0000, 4'h2, 0));
    vecs.push_back(mk(101, 16'h8765, 0, 0, 16'h0, 4'b0010, 4'h6, 0));
    vecs.push_back(mk(105, 16'h8765, 0, 0, 16'h0, 4'b0100, 4'h7, 0));

    reset = 1'b1;
    count_bus = 16'h4321;
    err_req = 1'b0;
    err_code = 16'h0;
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cur = 0;

    foreach (vecs[i]) begin
      count_bus = vecs[i].cnt;
      err_req = vecs[i].req;
      err_clr = vecs[i].clr;
      err_code = vecs[i].code;
      if (vecs[i].at > cur) begin
        step();
        err_req = 1'b0;
        err_clr = 1'b0;
        while (cur < vecs[i].at) step();
      end
      check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].val, vecs[i].err);
    end

    err_req = 1'b1;
    err_code = 16'hEC01;
    step();
    err_req = 1'b0;
    while (cur < 125) step();
    check("err_blank", 4'b0000, 4'hE, 1'b1);

    reset = 1'b1;
    step();
    reset = 1'b0;
    cur = 0;
    check("rst_in_err", 4'b0001, 4'h0, 1'b0);

    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_after_rst", 4'b0001, 4'h0, 1'b0);
    while (cur < 4) step();
    check("rst_idx0", 4'b0001, 4'h0, 1'b0);
    step();
    check("rst_snap0", 4'b0010, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
